dmem_responder: RTL and testbench
=================================

# dmem_responder

Synthesizable 128x32 data-memory responder for the single-cycle MIPS data port. It answers the CPU's active-low SRAM-style request (CEN/WEN/OEN/A/D), and replaces the behavioural data-memory macro in gate-level runs. A handshake load port streams initial contents into the array before the CPU leaves reset, replacing file-based preload.

## Interface
Parameters:
- AW, 7, address width
- DW, 32, data width
- DEPTH, 128, words in array (= 2**AW)

Ports (clock and reset first; reset is asynchronous and active-low; one clock domain):
- clk  in  1  clock; the CPU wrapper connects ~clk so memory samples mid-CPU-cycle
- rst_n  in  1  asynchronous active-low reset
- CEN  in  1  chip enable, active low
- WEN  in  1  write enable, active low; high = read
- OEN  in  1  output enable, active low
- A  in  AW  word address
- D  in  DW  write data (CPU ReadData2)
- Q  out  DW  read data (CPU ReadDataMem)
- ld_start  in  1  single-cycle pulse: begin preload
- ld_valid  in  1  ld_data valid
- ld_data  in  DW  preload word
- ld_ready  out  1  array accepts a preload word this cycle
- ld_busy  out  1  preload in progress; CPU port ignored
- ld_done  out  1  one-cycle pulse after last preload word

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: CPU port active. ld_start=1 -> LOAD, load pointer cleared to 0.
- LOAD: ld_ready=1, ld_busy=1. Each cycle with ld_valid=1 writes ld_data to mem[ptr] and increments ptr. Write at ptr=DEPTH-1 -> DONE. ld_valid=0 stalls; no timeout.
- DONE: ld_done=1 for exactly one cycle, ld_busy=0 -> IDLE.
- ld_start in LOAD or DONE is ignored.
- CPU port (IDLE only; ignored in LOAD/DONE, read register holds):
  - CEN=0, WEN=0: mem[A] <= D. Read register unchanged.
  - CEN=0, WEN=1: read register <= mem[A].
  - CEN=1: no access; read register holds.
- Q = read register when OEN=0, else all zeros. There is no tristate.
- Read and write of the same word are never simultaneous, because the port is single-port.
- A is always in range (AW bits, DEPTH = 2**AW), so there is no address check.

## Timing
- Reset values: Q register 0, state IDLE, ptr 0, ld_ready 0, ld_busy 0, ld_done 0.
- Array contents are not reset and survive rst_n.
- Read latency: one edge. Q shows mem[A] right after the sampling edge. With the ~clk connection, this is mid-cycle, which is in time for CPU write-back at the next rising clk.
- Write takes effect at the sampling edge. A read of the same address on the next edge returns the new data.
- ld_ready and ld_busy are registered state decodes. They rise the edge after ld_start and fall the edge after the last accepted word.
- Preload of DEPTH words takes DEPTH + 2 edges minimum: start, DEPTH writes, then DONE.
- Reset mid-load returns to IDLE immediately. Words already written are retained, ptr returns to 0, and no ld_done is emitted.
- ptr does not wrap past DEPTH-1, because the FSM leaves LOAD on that write.

## Configuration
- DMEM_ACCESS_CNT_EN
  - Defined: adds outputs rd_cnt[15:0] and wr_cnt[15:0].
    - They count accepted CPU reads and writes in IDLE.
    - They saturate at 16'hFFFF, reset to 0, and are not incremented by preload.
  - Undefined: these ports and counters are absent, and the behaviour is otherwise identical.

## Test plan
- Reset, then preload 128 words with value = index; read A=0 and A=1 -> Q=0 then 1. ld_done high for exactly 1 cycle after word 127.
- Preload with data 15 at word 0 and 20 at word 1. Write CEN=0, WEN=0, A=4, D=30, then read A=4 -> Q=30 on the next edge. Word 0 still reads 15.
- Drop ld_valid for 5 cycles at ptr=64 -> ld_ready stays 1, ptr holds. Resume -> word 64 receives the next ld_data, and ld_done occurs after word 127.
- Assert rst_n=0 at ptr=10 -> state IDLE, ld_busy=0, no ld_done. Words 0..9 retain their loaded values, and word 10 keeps its pre-load value.
- OEN=1 during a read of A=1 holding 20 -> Q=0. OEN=0 -> Q=20 without a new access. CEN=1 keeps Q stable.
- With DMEM_ACCESS_CNT_EN defined: 3 reads and 2 writes -> rd_cnt=3, wr_cnt=2. A CPU write issued during LOAD is ignored and not counted.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: 128x32 single-port data memory for the MIPS data port, with a handshake preload port.
// Define DMEM_ACCESS_CNT_EN to add saturating CPU read/write counters (rd_cnt, wr_cnt).
module dmem_responder #(
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_ptr;
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_idle;
    logic w_cpu_rd;
    logic w_cpu_wr;
    logic w_ld_wr;
    logic w_ld_last;

    assign w_idle    = (r_state == S_IDLE);
    assign w_cpu_rd  = w_idle && !CEN && WEN;
    assign w_cpu_wr  = w_idle && !CEN && !WEN;
    assign w_ld_wr   = (r_state == S_LOAD) && ld_valid;
    assign w_ld_last = (r_ptr == LAST_PTR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ld_start) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                    end
                end
                S_LOAD: begin
                    // Leaving LOAD on the last word keeps ptr from wrapping.
                    if (ld_valid) begin
                        if (w_ld_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ptr <= r_ptr + AW'(1);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_ld_wr) begin
            r_mem[r_ptr] <= ld_data;
        end else if (w_cpu_wr) begin
            r_mem[A] <= D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (w_cpu_rd) begin
            r_q <= r_mem[A];
        end
    end

    assign Q        = OEN ? '0 : r_q;
    assign ld_ready = (r_state == S_LOAD);
    assign ld_busy  = (r_state == S_LOAD);
    assign ld_done  = (r_state == S_DONE);

`ifdef DMEM_ACCESS_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_cpu_rd) r_rd_cnt <= sat_inc(r_rd_cnt);
            if (w_cpu_wr) r_wr_cnt <= sat_inc(r_wr_cnt);
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: preload handshake, CPU reads/writes, OEN/CEN, reset mid-load.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CEN, WEN, OEN;
    logic [6:0]  A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        ld_start, ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready, ld_busy, ld_done;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt, wr_cnt;
`endif

    dmem_responder #(.AW(7), .DW(32), .DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_busy(ld_busy),
`ifdef DMEM_ACCESS_CNT_EN
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
`endif
        .ld_done(ld_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_mem [128];
    logic [31:0] ld_vals [128];
    logic [31:0] sb_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int a, input logic [31:0] d);
        CEN = 1'b0; WEN = 1'b0; A = 7'(a); D = d;
        step();
        exp_mem[a] = d;
        CEN = 1'b1; WEN = 1'b1;
    endtask

    task automatic cpu_read(input int a);
        CEN = 1'b0; WEN = 1'b1; A = 7'(a);
        sb_q.push_back(exp_mem[a]);
        step();
        CEN = 1'b1;
        check_val("rd_data", Q, sb_q.pop_front());
    endtask

    // Streams ld_vals[] with an optional stall and an optional CPU write issued mid-load.
    task automatic do_load(input int stall_at, input int stall_len, input int cpu_wr_at);
        int done_cnt;
        done_cnt = 0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check_val("ld_ready_rise", 32'(ld_ready), 32'd1);
        check_val("ld_busy_rise", 32'(ld_busy), 32'd1);
        for (int i = 0; i < 128; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ld_valid = 1'b0;
                    step();
                    check_val("stall_ready", 32'(ld_ready), 32'd1);
                    check_val("stall_no_done", 32'(ld_done), 32'd0);
                end
            end
            if (i == cpu_wr_at) begin
                CEN = 1'b0; WEN = 1'b0; A = 7'd0; D = 32'd999;
            end
            ld_valid = 1'b1;
            ld_data  = ld_vals[i];
            step();
            CEN = 1'b1; WEN = 1'b1;
            exp_mem[i] = ld_vals[i];
            if (ld_done) done_cnt++;
        end
        ld_valid = 1'b0;
        check_val("done_pulse", 32'(ld_done), 32'd1);
        check_val("done_count", 32'(done_cnt), 32'd1);
        check_val("busy_fall", 32'(ld_busy), 32'd0);
        check_val("ready_fall", 32'(ld_ready), 32'd0);
        step();
        check_val("done_single", 32'(ld_done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; CEN = 1'b1; WEN = 1'b1; OEN = 1'b0; A = '0; D = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        step();
        step();
        check_val("rst_q", Q, 32'd0);
        check_val("rst_ready", 32'(ld_ready), 32'd0);
        check_val("rst_busy", 32'(ld_busy), 32'd0);
        check_val("rst_done", 32'(ld_done), 32'd0);
        rst_n = 1'b1;
        step();

        // Index preload, stalled for 5 cycles at word 64.
        for (int i = 0; i < 128; i++) ld_vals[i] = 32'(i);
        do_load(64, 5, -1);
        for (int i = 0; i < 128; i++) cpu_read(i);

        // Second preload, CPU write then read-back.
        for (int i = 0; i < 128; i++) ld_vals[i] = 32'(100 + i);
        ld_vals[0] = 32'd15;
        ld_vals[1] = 32'd20;
        do_load(-1, 0, -1);
        cpu_write(4, 32'd30);
        cpu_read(4);
        cpu_read(0);
        cpu_read(1);

        // Output enable and chip enable behaviour.
        OEN = 1'b1; CEN = 1'b0; WEN = 1'b1; A = 7'd1;
        step();
        CEN = 1'b1;
        check_val("oen_high", Q, 32'd0);
        OEN = 1'b0;
        #1;
        check_val("oen_low", Q, 32'd20);
        A = 7'd4;
        step();
        check_val("cen_hold", Q, 32'd20);

        // Reset asserted after 10 words of a preload.
        for (int i = 0; i < 128; i++) ld_vals[i] = 32'(500 + i);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1; ld_data = ld_vals[i];
            step();
            exp_mem[i] = ld_vals[i];
        end
        ld_data = ld_vals[10];
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(ld_busy), 32'd0);
        check_val("abort_ready", 32'(ld_ready), 32'd0);
        check_val("abort_done", 32'(ld_done), 32'd0);
        check_val("abort_q", Q, 32'd0);
        ld_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("abort_no_done", 32'(ld_done), 32'd0);
            check_val("abort_idle", 32'(ld_busy), 32'd0);
        end
`ifdef DMEM_ACCESS_CNT_EN
        check_val("cnt_rst_rd", 32'(rd_cnt), 32'd0);
        check_val("cnt_rst_wr", 32'(wr_cnt), 32'd0);
`endif
        for (int i = 0; i < 12; i++) cpu_read(i);
        cpu_write(20, 32'hA5A5_0014);
        cpu_write(21, 32'h5A5A_0015);
        cpu_read(20);
        cpu_read(21);
`ifdef DMEM_ACCESS_CNT_EN
        check_val("cnt_rd", 32'(rd_cnt), 32'd14);
        check_val("cnt_wr", 32'(wr_cnt), 32'd2);
`endif

        // CPU write during LOAD is ignored (word 0 keeps its load value).
        for (int i = 0; i < 128; i++) ld_vals[i] = 32'(700 + i);
        do_load(-1, 0, 5);
`ifdef DMEM_ACCESS_CNT_EN
        check_val("cnt_load_wr", 32'(wr_cnt), 32'd2);
        check_val("cnt_load_rd", 32'(rd_cnt), 32'd14);
`endif
        cpu_read(0);
        cpu_read(5);
        cpu_read(127);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
